// File: rtl/corner_marker_ctrl.sv
// Corner position store and crosshair overlay for the rectilinearizer.
// Optional feature: define CORNER_BLINK_EN to blink the selected marker.
module corner_marker_ctrl #(
    parameter int          ARM        = 20,
    parameter logic [29:0] COLOUR     = 30'h3FFFFFFF,
    parameter logic [29:0] SEL_COLOUR = 30'h3FF00000,
    parameter int          H_MAX      = 1023,
    parameter int          V_MAX      = 767,
    parameter int          REPEAT     = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        new_frame,
    input  logic        det_valid,
    output logic        det_ready,
    input  logic [1:0]  det_idx,
    input  logic [10:0] det_x,
    input  logic [9:0]  det_y,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [1:0]  sel_idx,
    output logic [43:0] corners_x,
    output logic [39:0] corners_y,
    output logic [29:0] pixel
);

    localparam int RW = $clog2(REPEAT + 1);
    localparam logic [10:0] RST_X [4] = '{11'd100, 11'd923, 11'd923, 11'd100};
    localparam logic [9:0]  RST_Y [4] = '{10'd100, 10'd100, 10'd667, 10'd667};
    localparam logic signed [11:0] ARM_S = 12'(ARM);

    typedef enum logic [1:0] {IDLE, NUDGE, COMMIT} state_t;

    state_t        state, next_state;
    logic [10:0]   shadow_x [4];
    logic [9:0]    shadow_y [4];
    logic [10:0]   active_x [4];
    logic [9:0]    active_y [4];
    logic [RW-1:0] rep_cnt;
    logic          btn_next_q;
    logic          any_dir, move;
    logic [10:0]   cur_x, nudge_x, clamp_x;
    logic [9:0]    cur_y, nudge_y, clamp_y;
    logic [3:0]    hit, sel_mask;
    logic          sel_hit, other_hit, blank;
    logic signed [11:0] hc, vc, sx, sy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        det_ready  = 1'b0;
        case (state)
            IDLE: begin
                det_ready = 1'b1;
                if (new_frame) next_state = NUDGE;
            end
            NUDGE:   next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Single-pixel move of the selected shadow corner, saturating at the edges
    always_comb begin
        any_dir = btn_up | btn_down | btn_left | btn_right;
        move    = any_dir && (rep_cnt == '0);
        cur_x   = shadow_x[sel_idx];
        cur_y   = shadow_y[sel_idx];
        nudge_x = cur_x;
        nudge_y = cur_y;
        if (move) begin
            if (btn_right && !btn_left && cur_x < 11'(H_MAX)) nudge_x = cur_x + 11'd1;
            else if (btn_left && !btn_right && cur_x != '0)   nudge_x = cur_x - 11'd1;
            if (btn_down && !btn_up && cur_y < 10'(V_MAX))    nudge_y = cur_y + 10'd1;
            else if (btn_up && !btn_down && cur_y != '0)      nudge_y = cur_y - 10'd1;
        end
        clamp_x = (det_x > 11'(H_MAX)) ? 11'(H_MAX) : det_x;
        clamp_y = (det_y > 10'(V_MAX)) ? 10'(V_MAX) : det_y;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow_x[i] <= RST_X[i];
                shadow_y[i] <= RST_Y[i];
                active_x[i] <= RST_X[i];
                active_y[i] <= RST_Y[i];
            end
            rep_cnt    <= '0;
            sel_idx    <= 2'd0;
            btn_next_q <= 1'b0;
        end else begin
            btn_next_q <= btn_next;
            if (btn_next && !btn_next_q) sel_idx <= sel_idx + 2'd1;
            if (det_valid && det_ready) begin
                shadow_x[det_idx] <= clamp_x;
                shadow_y[det_idx] <= clamp_y;
            end
            if (state == NUDGE) begin
                shadow_x[sel_idx] <= nudge_x;
                shadow_y[sel_idx] <= nudge_y;
                if (!any_dir)  rep_cnt <= '0;
                else if (move) rep_cnt <= RW'(REPEAT - 1);
                else           rep_cnt <= rep_cnt - 1'b1;
            end
            if (state == COMMIT) begin
                for (int i = 0; i < 4; i++) begin
                    active_x[i] <= shadow_x[i];
                    active_y[i] <= shadow_y[i];
                end
            end
        end
    end

`ifdef CORNER_BLINK_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)              frame_cnt <= 5'd0;
        else if (state == COMMIT)  frame_cnt <= frame_cnt + 5'd1;
    end

    assign blank = frame_cnt[4];
`else
    assign blank = 1'b0;
`endif

    // Signed 12-bit compares keep the arm bounds from wrapping near the origin
    always_comb begin
        hc = {1'b0, hcount};
        vc = {2'b00, vcount};
        sx = '0;
        sy = '0;
        hit = '0;
        corners_x = '0;
        corners_y = '0;
        for (int i = 0; i < 4; i++) begin
            sx = {1'b0, active_x[i]};
            sy = {2'b00, active_y[i]};
            hit[i] = ((vc == sy) && (hc > sx - ARM_S) && (hc < sx + ARM_S)) ||
                     ((hc == sx) && (vc > sy - ARM_S) && (vc < sy + ARM_S));
            corners_x[11*i +: 11] = active_x[i];
            corners_y[10*i +: 10] = active_y[i];
        end
        sel_mask  = 4'b0001 << sel_idx;
        sel_hit   = |(hit & sel_mask) && !blank;
        other_hit = |(hit & ~sel_mask);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       pixel <= '0;
        else if (sel_hit)   pixel <= SEL_COLOUR;
        else if (other_hit) pixel <= COLOUR;
        else                pixel <= '0;
    end

endmodule

// File: tb/tb_corner_marker_ctrl.sv
// Randomized bench for corner_marker_ctrl against a frame-level position/overlay model.
module tb_corner_marker_ctrl;

    localparam int          ARM        = 20;
    localparam logic [29:0] COLOUR     = 30'h3FFFFFFF;
    localparam logic [29:0] SEL_COLOUR = 30'h3FF00000;
    localparam int          H_MAX      = 1023;
    localparam int          V_MAX      = 767;
    localparam int          REPEAT     = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        new_frame = 1'b0, det_valid = 1'b0, det_ready;
    logic [1:0]  det_idx = '0;
    logic [10:0] det_x = '0;
    logic [9:0]  det_y = '0;
    logic        btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [1:0]  sel_idx;
    logic [43:0] corners_x;
    logic [39:0] corners_y;
    logic [29:0] pixel;

    always #5 clock = ~clock;

    corner_marker_ctrl dut (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .new_frame(new_frame), .det_valid(det_valid), .det_ready(det_ready),
        .det_idx(det_idx), .det_x(det_x), .det_y(det_y), .btn_next(btn_next),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .sel_idx(sel_idx), .corners_x(corners_x), .corners_y(corners_y), .pixel(pixel)
    );

    int checks = 0;
    int errors = 0;

    // Model: shadow/active positions, selection, repeat count, frame phase (0 idle, 1 nudge due, 2 commit due)
    int mSx[4], mSy[4], mAx[4], mAy[4];
    int mSel, mRep, mPhase, mFrames, mPrevNext;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int clampi(input int val, input int hi);
        return (val < 0) ? 0 : ((val > hi) ? hi : val);
    endfunction

    task automatic modelReset();
        mSx = '{100, 923, 923, 100};
        mSy = '{100, 100, 667, 667};
        mAx = mSx;
        mAy = mSy;
        mSel = 0; mRep = 0; mPhase = 0; mFrames = 0; mPrevNext = 0;
    endtask

    function automatic logic [63:0] packX();
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) r = r | (64'(mAx[i]) << (11 * i));
        return r;
    endfunction

    function automatic logic [63:0] packY();
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) r = r | (64'(mAy[i]) << (10 * i));
        return r;
    endfunction

    function automatic logic [29:0] modelPixel(input int h, input int v);
        bit selHit = 0, otherHit = 0, blank = 0, hit;
`ifdef CORNER_BLINK_EN
        blank = (mFrames % 32) >= 16;
`endif
        for (int i = 0; i < 4; i++) begin
            hit = (v == mAy[i] && (h - mAx[i] < ARM) && (mAx[i] - h < ARM)) ||
                  (h == mAx[i] && (v - mAy[i] < ARM) && (mAy[i] - v < ARM));
            if (hit && i == mSel) selHit = !blank;
            else if (hit)         otherHit = 1;
        end
        return selHit ? SEL_COLOUR : (otherHit ? COLOUR : 30'd0);
    endfunction

    // One clock: drive at negedge, advance model, check after posedge, return at negedge
    task automatic applyStimulus(input bit nf, input bit dv, input int di, input int dx, input int dy,
                                 input bit nxt, input logic [3:0] dir, input int h, input int v);
        logic [29:0] expPix;
        int oldSel;
        new_frame = nf; det_valid = dv; det_idx = 2'(di); det_x = 11'(dx); det_y = 10'(dy);
        btn_next = nxt; {btn_up, btn_down, btn_left, btn_right} = dir;
        hcount = 11'(h); vcount = 10'(v);
        checkOutput("det_ready", 64'(det_ready), 64'(mPhase == 0));
        expPix = modelPixel(h, v);
        oldSel = mSel;
        if (nxt && !mPrevNext) mSel = (mSel + 1) % 4;
        mPrevNext = nxt;
        case (mPhase)
            0: begin
                if (dv) begin
                    mSx[di] = clampi(dx, H_MAX);
                    mSy[di] = clampi(dy, V_MAX);
                end
                if (nf) mPhase = 1;
            end
            1: begin
                if (dir == 4'b0000) mRep = 0;
                else if (mRep == 0) begin
                    mSx[oldSel] = clampi(mSx[oldSel] + int'(dir[0]) - int'(dir[1]), H_MAX);
                    mSy[oldSel] = clampi(mSy[oldSel] + int'(dir[2]) - int'(dir[3]), V_MAX);
                    mRep = REPEAT - 1;
                end else mRep--;
                mPhase = 2;
            end
            default: begin
                mAx = mSx;
                mAy = mSy;
                mFrames++;
                mPhase = 0;
            end
        endcase
        @(posedge clock);
        #1;
        checkOutput("pixel", 64'(pixel), 64'(expPix));
        checkOutput("sel_idx", 64'(sel_idx), 64'(mSel));
        checkOutput("corners_x", 64'(corners_x), packX());
        checkOutput("corners_y", 64'(corners_y), packY());
        @(negedge clock);
    endtask

    task automatic idle(input int h, input int v);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0000, h, v);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        new_frame = 0; det_valid = 0; btn_next = 0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        modelReset();
        #1;
        checkOutput("rst_ready", 64'(det_ready), 64'd1);
        checkOutput("rst_pixel", 64'(pixel), 64'd0);
        checkOutput("rst_sel", 64'(sel_idx), 64'd0);
        checkOutput("rst_cx", 64'(corners_x), packX());
        checkOutput("rst_cy", 64'(corners_y), packY());
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Frame with a held direction: strobe, nudge, commit, then one idle cycle
    task automatic runFrame(input logic [3:0] dir);
        applyStimulus(1, 0, 0, 0, 0, 0, dir, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, dir, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, dir, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, dir, 0, 0);
    endtask

    initial begin
        logic [3:0] dir;
        bit nxt;
        int c, h, v;

        @(negedge clock);
        doReset();

        $display("[TB] marker render after reset");
        idle(100, 100);
        checkOutput("t1_sel_centre", 64'(pixel), 64'(SEL_COLOUR));
        idle(119, 100);
        checkOutput("t1_arm_end", 64'(pixel), 64'(SEL_COLOUR));
        idle(120, 100);
        checkOutput("t1_arm_out", 64'(pixel), 64'd0);
        idle(923, 667);
        checkOutput("t1_unsel", 64'(pixel), 64'(COLOUR));

        $display("[TB] detector update and commit");
        applyStimulus(0, 1, 2, 500, 400, 0, 4'b0000, 0, 0);
        idle(0, 0);
        checkOutput("t2_before", 64'(corners_x[32:22]), 64'd923);
        applyStimulus(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        idle(0, 0);
        checkOutput("t2_mid", 64'(corners_x[32:22]), 64'd923);
        idle(0, 0);
        checkOutput("t2_after", 64'(corners_x[32:22]), 64'd500);

        $display("[TB] selection edges");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0);
            idle(0, 0);
        end
        checkOutput("t3_five", 64'(sel_idx), 64'd1);
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0);
        idle(0, 0);
        checkOutput("t3_held", 64'(sel_idx), 64'd2);

        $display("[TB] auto-repeat and saturation");
        doReset();
        applyStimulus(0, 1, 0, 2, 100, 0, 4'b0000, 0, 0);
        for (int f = 1; f <= 20; f++) begin
            runFrame(4'b0010);
            if (f == 1) checkOutput("t4_f1", 64'(corners_x[10:0]), 64'd1);
            if (f == 8) checkOutput("t4_f8", 64'(corners_x[10:0]), 64'd1);
            if (f == 9) checkOutput("t4_f9", 64'(corners_x[10:0]), 64'd0);
        end
        checkOutput("t4_f20", 64'(corners_x[10:0]), 64'd0);

        $display("[TB] transfer on strobe and origin render");
        applyStimulus(1, 1, 0, 10, 5, 0, 4'b0000, 0, 0);
        checkOutput("t5_busy1", 64'(det_ready), 64'd0);
        idle(0, 0);
        checkOutput("t5_busy2", 64'(det_ready), 64'd0);
        idle(0, 0);
        checkOutput("t5_ready", 64'(det_ready), 64'd1);
        checkOutput("t5_x0", 64'(corners_x[10:0]), 64'd10);
        checkOutput("t5_y0", 64'(corners_y[9:0]), 64'd5);
        idle(0, 5);
        checkOutput("t5_origin", 64'(pixel), 64'(SEL_COLOUR));
        idle(2047, 5);
        checkOutput("t5_nowrap", 64'(pixel), 64'd0);

        $display("[TB] reset during nudge");
        applyStimulus(1, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
        doReset();

        $display("[TB] randomized traffic");
        dir = 4'b0000;
        nxt = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) dir = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) nxt = !nxt;
            c = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                h = $urandom_range(0, 2047);
                v = $urandom_range(0, 1023);
            end else begin
                h = clampi(mAx[c] + $urandom_range(0, 50) - 25, 2047);
                v = ($urandom_range(0, 1) == 0) ? mAy[c] : clampi(mAy[c] + $urandom_range(0, 50) - 25, 1023);
                if ($urandom_range(0, 1) == 0) h = mAx[c];
            end
            applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                          $urandom_range(0, 2047), $urandom_range(0, 1023), nxt, dir, h, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
